// File: rtl/cam_capture.sv
// ---------------------------------------------------------------------------
// cam_capture
//
// Captures an RGB565 byte stream from a parallel camera (OV7670 style,
// high byte first) and turns it into RGB111 pixel writes for a frame
// buffer. One pixel is written per byte pair, addressed linearly from 0
// at the start of each frame.
//
// Parameters
//   AW      write-address width
//   DW      pixel data width (RGB111, R on bit 2)
//   WIDTH   pixels per line
//   HEIGHT  lines per frame
//
// Ports
//   clk         in   camera pixel clock (PCLK), the only clock
//   reset       in   asynchronous active-low reset
//   vsync       in   frame sync, high during vertical blanking
//   href        in   line valid, high while px_data carries bytes
//   px_data     in   RGB565 byte stream, high byte first
//   addr        out  frame-buffer write address
//   data        out  pixel value {R,G,B}
//   regwrite    out  one-cycle write strobe qualifying addr/data
//   frame_done  out  one-cycle pulse when the frame is complete
//
// Configuration
//   CAM_TESTPAT_EN  when defined, data carries a column colour bar
//                   (column[7:5]) instead of camera bits; the handshake,
//                   addressing and timing are identical.
// ---------------------------------------------------------------------------
module cam_capture #(
    parameter int AW     = 15,
    parameter int DW     = 3,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          regwrite,
    output logic          frame_done
);

    // The column counter is at least 8 bits so the colour-bar pattern can
    // always take bits [7:5] of it.
    localparam int CW_MIN = $clog2(WIDTH + 1);
    localparam int CW     = (CW_MIN < 8) ? 8 : CW_MIN;
    localparam int RW     = $clog2(HEIGHT + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
    localparam logic [CW-1:0] COLS      = CW'(WIDTH);
    localparam logic [RW-1:0] ROWS      = RW'(HEIGHT);

    typedef enum logic [2:0] {
        WAIT_VS,
        WAIT_FRAME,
        BYTE_HI,
        BYTE_LO,
        FULL
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          regwrite_q, regwrite_d;
    logic          frame_done_q, frame_done_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          r_q, r_d;
    logic          g_q, g_d;
    logic          href_q;
    logic          hrefFall;

    assign hrefFall = href_q && !href;

`ifdef CAM_TESTPAT_EN
    logic unused_bits;
    assign unused_bits = ^{px_data, r_q, g_q};
`else
    logic unused_bits;
    assign unused_bits = ^{px_data[6:5], px_data[3], px_data[1:0]};
`endif

    // State and output registers. Everything the outside world sees comes
    // straight from a flop, so downstream logic gets a full PCLK period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_VS;
            addr_q       <= '0;
            data_q       <= '0;
            regwrite_q   <= 1'b0;
            frame_done_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            r_q          <= 1'b0;
            g_q          <= 1'b0;
            href_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            regwrite_q   <= regwrite_d;
            frame_done_q <= frame_done_d;
            col_q        <= col_d;
            row_q        <= row_d;
            r_q          <= r_d;
            g_q          <= g_d;
            href_q       <= href;
        end
    end

    // Next-state logic. Priority inside the capture states is:
    // vsync abort, then end-of-line, then byte handling.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        regwrite_d   = 1'b0;
        frame_done_d = 1'b0;
        col_d        = col_q;
        row_d        = row_q;
        r_d          = r_q;
        g_d          = g_q;

        // The address presented with a write stays stable for that cycle
        // and steps afterwards; it never steps past the last pixel.
        if (regwrite_q && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + AW'(1);
        end

        unique case (state_q)
            WAIT_VS: begin
                if (vsync) begin
                    state_d = WAIT_FRAME;
                end
            end

            WAIT_FRAME: begin
                if (!vsync) begin
                    state_d = BYTE_HI;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            BYTE_HI, BYTE_LO: begin
                if (vsync) begin
                    state_d = WAIT_FRAME;
                end else if (hrefFall) begin
                    // End of line; a dangling high byte is simply forgotten.
                    state_d = BYTE_HI;
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    if (row_q == ROWS - RW'(1)) begin
                        frame_done_d = 1'b1;
                        state_d      = FULL;
                    end
                end else if (href) begin
                    if (state_q == BYTE_HI) begin
                        r_d     = px_data[7];
                        g_d     = px_data[2];
                        state_d = BYTE_LO;
                    end else begin
                        state_d = BYTE_HI;
                        // Pixels past the right edge are dropped entirely.
                        if (col_q < COLS) begin
                            regwrite_d = 1'b1;
                            col_d      = col_q + CW'(1);
`ifdef CAM_TESTPAT_EN
                            data_d     = DW'(col_q[7:5]);
`else
                            data_d     = DW'({r_q, g_q, px_data[4]});
`endif
                            if (addr_q == LAST_ADDR) begin
                                frame_done_d = 1'b1;
                                state_d      = FULL;
                            end
                        end
                    end
                end
            end

            FULL: begin
                if (vsync) begin
                    state_d = WAIT_FRAME;
                end
            end

            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    assign addr       = addr_q;
    assign data       = data_q;
    assign regwrite   = regwrite_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_capture
//
// Drives whole camera frames described as a list of line byte counts with
// random byte values. While driving, a frame-level model works out which
// low bytes become pixel writes (pixel index within the line below WIDTH,
// frame not yet full) and queues the expected write, address, data and
// frame_done for the cycle they must appear. A single compare process
// checks the DUT against that queue on every cycle; directed frames add
// literal checks on the observed write log.
// ---------------------------------------------------------------------------
module tb_cam_capture;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int LAST   = WIDTH * HEIGHT - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  px_data = 8'h00;
    logic [14:0] addr;
    logic [2:0]  data;
    logic        regwrite;
    logic        frame_done;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        logic [14:0] a;
        logic [2:0]  d;
        bit          wr;
        bit          fd;
    } ev_t;

    ev_t         expQ[$];
    int          lineLen[$];
    logic [7:0]  preset[$];

    logic [14:0] obsAddr[$];
    logic [2:0]  obsData[$];
    logic [14:0] obsNext[$];
    int          fdCount = 0;
    int          fdAddr = 0;
    bit          fdWithWr = 1'b0;

    cam_capture #(
        .AW(15),
        .DW(3),
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vsync(vsync),
        .href(href),
        .px_data(px_data),
        .addr(addr),
        .data(data),
        .regwrite(regwrite),
        .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 2 time units after the falling edge, then we wait for
    // the next drive slot; the rising edge in between samples them.
    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
        vsync   = v;
        href    = h;
        px_data = d;
        @(negedge clk);
        #2;
    endtask

    function automatic logic [7:0] nextByte();
        if (preset.size() > 0) return preset.pop_front();
        return 8'($urandom);
    endfunction

    task automatic clearLogs();
        obsAddr.delete();
        obsData.delete();
        obsNext.delete();
        fdCount  = 0;
        fdAddr   = 0;
        fdWithWr = 1'b0;
    endtask

    // Compare process: every falling edge, outputs against the model queue.
    ev_t         cmpEv;
    bit          curWr;
    bit          curFd;
    bit          prevWr = 1'b0;
    logic [14:0] prevNext = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                checkOutput("reset addr", int'(addr), 0);
                checkOutput("reset data", int'(data), 0);
                checkOutput("reset regwrite", int'(regwrite), 0);
                checkOutput("reset frame_done", int'(frame_done), 0);
                prevWr = 1'b0;
            end else begin
                while (expQ.size() > 0 && expQ[0].due < cyc) begin
                    cmpEv = expQ.pop_front();
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL stale event: due %0d, now %0d", cmpEv.due, cyc);
                end
                curWr = 1'b0;
                curFd = 1'b0;
                if (expQ.size() > 0 && expQ[0].due == cyc) begin
                    cmpEv = expQ.pop_front();
                    curWr = cmpEv.wr;
                    curFd = cmpEv.fd;
                end
                if (prevWr) begin
                    checkOutput("addr after write", int'(addr), int'(prevNext));
                    obsNext.push_back(addr);
                end
                checkOutput("regwrite", int'(regwrite), int'(curWr));
                checkOutput("frame_done", int'(frame_done), int'(curFd));
                if (curWr) begin
                    checkOutput("write addr", int'(addr), int'(cmpEv.a));
                    checkOutput("write data", int'(data), int'(cmpEv.d));
                    prevNext = (int'(cmpEv.a) == LAST) ? cmpEv.a : cmpEv.a + 15'd1;
                end
                if (regwrite) begin
                    obsAddr.push_back(addr);
                    obsData.push_back(data);
                end
                if (frame_done) begin
                    fdCount++;
                    fdAddr   = int'(addr);
                    fdWithWr = regwrite;
                end
                prevWr = curWr;
            end
        end
    end

    // Drives one frame from lineLen and queues what the frame-level rules
    // say must come out. abortPixel >= 0 raises vsync on that pixel's low
    // byte (pixels counted across the frame, dropped ones included).
    task automatic runFrame(input int abortPixel);
        int         pixAddr;
        int         row;
        int         pixCount;
        int         p;
        bit         full;
        bit         stop;
        logic [7:0] hi;
        logic [7:0] b;
        logic [7:0] col;
        ev_t        ev;
        pixAddr  = 0;
        row      = 0;
        pixCount = 0;
        full     = 1'b0;
        stop     = 1'b0;
        hi       = 8'h00;
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        foreach (lineLen[l]) begin
            if (stop) break;
            p = 0;
            for (int bi = 0; bi < lineLen[l]; bi++) begin
                b = nextByte();
                if (bi % 2 == 0) begin
                    hi = b;
                    applyStimulus(1'b0, 1'b1, b);
                end else begin
                    if (pixCount == abortPixel) begin
                        applyStimulus(1'b1, 1'b1, b);
                        stop = 1'b1;
                        break;
                    end
                    if (!full && p < WIDTH) begin
                        col   = 8'(p);
                        ev.due = cyc + 1;
                        ev.a   = 15'(pixAddr);
                        ev.wr  = 1'b1;
`ifdef CAM_TESTPAT_EN
                        ev.d   = col[7:5];
`else
                        ev.d   = {hi[7], hi[2], b[4]};
`endif
                        ev.fd  = (pixAddr == LAST);
                        expQ.push_back(ev);
                        if (ev.fd) full = 1'b1;
                        pixAddr++;
                    end
                    p++;
                    pixCount++;
                    applyStimulus(1'b0, 1'b1, b);
                end
            end
            if (!stop) begin
                if (!full && lineLen[l] > 0) begin
                    row++;
                    if (row == HEIGHT) begin
                        ev.due = cyc + 1;
                        ev.a   = '0;
                        ev.d   = '0;
                        ev.wr  = 1'b0;
                        ev.fd  = 1'b1;
                        expQ.push_back(ev);
                        full = 1'b1;
                    end
                end
                repeat (1 + $urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 8'($urandom));
            end
        end
        if (stop) applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int nLines;
        int abortAt;

        // Reset held for a few cycles; compare process checks the zeros.
        @(negedge clk);
        #2;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

        // Directed frame: known first pixels, overlong line, odd line.
        clearLogs();
        preset = {8'h84, 8'h10, 8'h04, 8'h00};
        lineLen = {340, 3, 4, 7};
        runFrame(-1);
        checkOutput("px0 addr", int'(obsAddr[0]), 0);
        checkOutput("px1 addr", int'(obsAddr[1]), 1);
        checkOutput("addr after px1", int'(obsNext[1]), 2);
`ifdef CAM_TESTPAT_EN
        checkOutput("px0 data", int'(obsData[0]), 0);
        checkOutput("px1 data", int'(obsData[1]), 0);
`else
        checkOutput("px0 data", int'(obsData[0]), 7);
        checkOutput("px1 data", int'(obsData[1]), 2);
`endif
        checkOutput("line0 last addr", int'(obsAddr[159]), 159);
        checkOutput("line1 first addr", int'(obsAddr[160]), 160);
        checkOutput("line2 first addr", int'(obsAddr[161]), 161);
        checkOutput("directed write count", obsAddr.size(), 166);

        // Abort at pixel 500 (line 3, column 20), then resume from 0.
        clearLogs();
        lineLen = {320, 320, 320, 320};
        runFrame(500);
        checkOutput("abort write count", obsAddr.size(), 500);
        checkOutput("abort last addr", int'(obsAddr[499]), 499);
        checkOutput("abort frame_done", fdCount, 0);
        clearLogs();
        lineLen = {6};
        runFrame(-1);
        checkOutput("post-abort first addr", int'(obsAddr[0]), 0);
        checkOutput("post-abort count", obsAddr.size(), 3);

        // Reset while in the low-byte state, then bytes without vsync.
        lineLen = {10};
        runFrame(-1);
        applyStimulus(1'b0, 1'b1, 8'($urandom));
        reset = 1'b0;
        expQ.delete();
        repeat (3) applyStimulus(1'b0, 1'b1, 8'($urandom));
        reset = 1'b1;
        clearLogs();
        repeat (3) begin
            repeat (20) applyStimulus(1'b0, 1'b1, 8'($urandom));
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        checkOutput("no write before vsync", obsAddr.size(), 0);
        lineLen = {8};
        runFrame(-1);
        checkOutput("post-reset first addr", int'(obsAddr[0]), 0);
        checkOutput("post-reset count", obsAddr.size(), 4);

        // Frame ended by the row count: 120 short lines then two extras.
        clearLogs();
        lineLen.delete();
        repeat (HEIGHT + 2) lineLen.push_back($urandom_range(1, 9));
        runFrame(-1);
        checkOutput("row frame_done count", fdCount, 1);
        checkOutput("row frame_done no write", int'(fdWithWr), 0);

        // Random frames, some aborted.
        repeat (6) begin
            lineLen.delete();
            nLines = $urandom_range(1, 6);
            repeat (nLines) lineLen.push_back($urandom_range(1, 350));
            abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 600) : -1;
            runFrame(abortAt);
        end

        // Full 160x120 frame plus bytes that must be ignored.
        clearLogs();
        lineLen.delete();
        repeat (HEIGHT) lineLen.push_back(2 * WIDTH);
        repeat (2) lineLen.push_back(40);
        runFrame(-1);
        checkOutput("full write count", obsAddr.size(), WIDTH * HEIGHT);
        checkOutput("full last addr", int'(obsAddr[LAST]), LAST);
        checkOutput("full frame_done count", fdCount, 1);
        checkOutput("full frame_done addr", fdAddr, LAST);
        checkOutput("full frame_done with write", int'(fdWithWr), 1);
        clearLogs();
        lineLen = {4};
        runFrame(-1);
        checkOutput("after full first addr", int'(obsAddr[0]), 0);

        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
